// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle processor control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and counts the
// instructions it retires in a saturating counter.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an illegal
// opcode parks the unit in TRAP until reset. When it is undefined, an illegal
// opcode retires as a NOP.
// DECODE outputs come from the live Opcode input, because op_q is only written
// at the end of DECODE. EXEC, MEM and WB decode from the latched op_q.
module mc_ctrl_unit #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Run,
    input  logic [OPW-1:0]   Opcode,
    input  logic             MemReady,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             RegDes,
    output logic             AluSrc,
    output logic             Mem2Reg,
    output logic             MemR,
    output logic             MemW,
    output logic             Branch,
    output logic             Jump,
    output logic             sti,
    output logic             Busy,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_WB,
        S_TRAP
`else
        S_WB
`endif
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE,
        K_ST,
        K_LD,
        K_IMM,
        K_BR,
        K_JMP,
        K_HALT,
        K_ILL
    } kind_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    kind_t            dec_kind, op_kind;

    function automatic kind_t classify(input logic [OPW-1:0] op);
        kind_t k;
        if (op == '1)                k = K_HALT;
        else if (op <= OPW'(5))      k = K_RTYPE;
        else if (op == OPW'(6))      k = K_ST;
        else if (op == OPW'(7))      k = K_LD;
        else if (op == OPW'(8))      k = K_IMM;
        else if (op == OPW'(9))      k = K_BR;
        else if (op == OPW'(10))     k = K_JMP;
        else                         k = K_ILL;
        return k;
    endfunction

    assign dec_kind   = classify(Opcode);
    assign op_kind    = classify(op_q);
    assign InstrCount = cnt_q;

    // State, latched opcode and saturating retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= Opcode;
            end
            if (retire && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state, retire and control outputs from the state and opcode.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        RegWr     = 1'b0;
        RegDes    = 1'b0;
        AluSrc    = 1'b0;
        Mem2Reg   = 1'b0;
        MemR      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        sti       = 1'b0;
        Busy      = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                Busy = 1'b1;
                MemR = 1'b1;
                if (MemReady) begin
                    PCWr    = 1'b1;
                    IRWr    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                Busy = 1'b1;
                case (dec_kind)
                    K_JMP: begin
                        Jump    = 1'b1;
                        PCWr    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_HALT: begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                    K_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                Busy = 1'b1;
                case (op_kind)
                    K_RTYPE: state_d = S_WB;
                    K_IMM: begin
                        AluSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    K_LD, K_ST: begin
                        AluSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    K_BR: begin
                        Branch  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                Busy = 1'b1;
                if (op_kind == K_LD) begin
                    MemR = 1'b1;
                    if (MemReady) state_d = S_WB;
                end else begin
                    MemW = 1'b1;
                    sti  = 1'b1;
                    if (MemReady) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                Busy    = 1'b1;
                RegWr   = 1'b1;
                RegDes  = (op_kind == K_RTYPE);
                Mem2Reg = (op_kind == K_LD);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                IllegalOp = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Testbench for mc_ctrl_unit.
// Each instruction is expanded into its expected per-cycle timeline, which
// carries the inputs to drive and the outputs and counts to expect.
// Two instances are driven in parallel: CNT_W=16 and CNT_W=2. The second
// instance exercises counter saturation.
module tb_mc_ctrl_unit;

    typedef struct packed {
        logic PCWr, IRWr, RegWr, RegDes, AluSrc, Mem2Reg, MemR, MemW,
              Branch, Jump, sti, Busy, IllegalOp;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic       run;
        logic       mrdy;
        logic [3:0] op;
        outs_t      exp;
        bit         retire;
        bit         clr;
        int         lit;
        int         lit2;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n, Run, MemReady;
    logic [3:0]  Opcode;
    logic [12:0] oa, ob;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    mc_ctrl_unit #(.OPW(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
        .PCWr(oa[12]), .IRWr(oa[11]), .RegWr(oa[10]), .RegDes(oa[9]),
        .AluSrc(oa[8]), .Mem2Reg(oa[7]), .MemR(oa[6]), .MemW(oa[5]),
        .Branch(oa[4]), .Jump(oa[3]), .sti(oa[2]), .Busy(oa[1]),
        .IllegalOp(oa[0]), .InstrCount(cnt_a)
    );

    mc_ctrl_unit #(.OPW(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
        .PCWr(ob[12]), .IRWr(ob[11]), .RegWr(ob[10]), .RegDes(ob[9]),
        .AluSrc(ob[8]), .Mem2Reg(ob[7]), .MemR(ob[6]), .MemW(ob[5]),
        .Branch(ob[4]), .Jump(ob[3]), .sti(ob[2]), .Busy(ob[1]),
        .IllegalOp(ob[0]), .InstrCount(cnt_b)
    );

    int          errors = 0;
    int          checks = 0;
    cyc_t        q[$];
    cyc_t        cur;
    bit          chk_en = 1'b0;
    int unsigned model_n = 0;
    int unsigned cur_n = 0;
    int          next_lit = -1;
    int          next_lit2 = -1;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
        end
    endfunction

    function automatic logic [31:0] sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic r, input logic run, input logic mr, input logic [3:0] op,
                        input outs_t e, input bit ret, input bit clr);
        cyc_t c;
        c.rst_n = r; c.run = run; c.mrdy = mr; c.op = op; c.exp = e;
        c.retire = ret; c.clr = clr; c.lit = next_lit; c.lit2 = next_lit2;
        next_lit = -1;
        next_lit2 = -1;
        q.push_back(c);
    endtask

    // One instruction: fw fetch wait cycles, mw memory wait cycles.
    task automatic instr(input logic [3:0] op, input int fw, input int mw, output int n);
        outs_t e;
        int    s;
        bit    is_r, is_st, is_ld, is_imm, is_br, is_jmp, is_halt, is_ill, dec_ret;
        s = q.size();
        is_r    = (op <= 4'd5);
        is_st   = (op == 4'd6);
        is_ld   = (op == 4'd7);
        is_imm  = (op == 4'd8);
        is_br   = (op == 4'd9);
        is_jmp  = (op == 4'd10);
        is_halt = (op == 4'd15);
        is_ill  = !(is_r || is_st || is_ld || is_imm || is_br || is_jmp || is_halt);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.MemR = 1; e.Busy = 1;
            push(1, rb(), 0, rop(), e, 0, 0);
        end
        e = '0; e.MemR = 1; e.Busy = 1; e.PCWr = 1; e.IRWr = 1;
        push(1, rb(), 1, rop(), e, 0, 0);
        e = '0; e.Busy = 1;
        if (is_jmp) begin e.Jump = 1; e.PCWr = 1; end
        dec_ret = is_jmp || is_halt;
`ifndef CTRL_ILLEGAL_TRAP_EN
        dec_ret = dec_ret || is_ill;
`endif
        push(1, rb(), rb(), op, e, dec_ret, 0);
        if (!(is_jmp || is_halt || is_ill)) begin
            e = '0; e.Busy = 1; e.AluSrc = is_st || is_ld || is_imm; e.Branch = is_br;
            push(1, rb(), rb(), rop(), e, is_br, 0);
            if (is_st || is_ld) begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.Busy = 1; e.MemR = is_ld; e.MemW = is_st; e.sti = is_st;
                    push(1, rb(), (i == mw), rop(), e, is_st && (i == mw), 0);
                end
            end
            if (!is_br && !is_st) begin
                e = '0; e.Busy = 1; e.RegWr = 1; e.RegDes = is_r; e.Mem2Reg = is_ld;
                push(1, rb(), rb(), rop(), e, 1, 0);
            end
        end
        n = q.size() - s;
    endtask

    task automatic idle(input int n, input bit start);
        for (int i = 0; i < n; i++) push(1, 0, rb(), rop(), '0, 0, 0);
        if (start) push(1, 1, rb(), rop(), '0, 0, 0);
    endtask

    // Reset cycle: e is what the unit shows while reset is being sampled.
    task automatic rst_cycle(input outs_t e);
        push(0, rb(), rb(), rop(), e, 0, 1);
    endtask

    // Load aborted by reset while waiting on memory.
    task automatic ld_abort(input int mw_before);
        outs_t e;
        e = '0; e.MemR = 1; e.Busy = 1; e.PCWr = 1; e.IRWr = 1;
        push(1, rb(), 1, rop(), e, 0, 0);
        e = '0; e.Busy = 1;
        push(1, rb(), rb(), 4'd7, e, 0, 0);
        e = '0; e.Busy = 1; e.AluSrc = 1;
        push(1, rb(), rb(), rop(), e, 0, 0);
        e = '0; e.Busy = 1; e.MemR = 1;
        for (int i = 0; i < mw_before; i++) push(1, rb(), 0, rop(), e, 0, 0);
        push(0, rb(), 0, rop(), e, 0, 1);
    endtask

`ifdef CTRL_ILLEGAL_TRAP_EN
    task automatic trap_seq(input int n);
        outs_t e;
        e = '0; e.IllegalOp = 1;
        for (int i = 0; i < n; i++) push(1, 1, rb(), rop(), e, 0, 0);
        rst_cycle(e);
    endtask
`endif

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst_n = c.rst_n; Run = c.run; MemReady = c.mrdy; Opcode = c.op;
            cur = c;
            cur_n = model_n;
            chk_en = 1'b1;
            if (c.clr) model_n = 0;
            else if (c.retire) model_n++;
        end
    endtask

    // Compare both instances against the current timeline entry.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("outs", 32'(oa), 32'(cur.exp));
            chk("outs_w2", 32'(ob), 32'(cur.exp));
            chk("memr_memw_excl", 32'(oa[6] & oa[5]), 32'd0);
            chk("cnt", 32'(cnt_a), sat(cur_n, 65535));
            chk("cnt_w2", 32'(cnt_b), sat(cur_n, 3));
            if (cur.lit >= 0) chk("cnt_lit", 32'(cnt_a), 32'(cur.lit));
            if (cur.lit2 >= 0) chk("cnt_w2_lit", 32'(cnt_b), 32'(cur.lit2));
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; Run = 1'b0; MemReady = 1'b0; Opcode = '0;
        repeat (2) @(posedge clk);

        next_lit = 0;
        rst_cycle('0);
        idle(2, 1);
        instr(4'd0, 0, 0, n);  chk("lat_rtype", n, 4);
        next_lit = 1;
        instr(4'd0, 0, 0, n);
        instr(4'd0, 0, 0, n);
        instr(4'd5, 2, 0, n);  chk("lat_rtype_fw2", n, 6);
        instr(4'd8, 0, 0, n);  chk("lat_imm", n, 4);
        instr(4'd9, 0, 0, n);  chk("lat_branch", n, 3);
        instr(4'd10, 0, 0, n); chk("lat_jump", n, 2);
        instr(4'd7, 0, 3, n);  chk("lat_ld_mw3", n, 8);
        next_lit = 8;
        instr(4'd6, 0, 0, n);  chk("lat_st", n, 4);
        instr(4'd6, 0, 2, n);
        instr(4'd15, 0, 0, n); chk("lat_halt", n, 2);
        next_lit = 11;
        idle(1, 1);
        instr(4'd12, 0, 0, n);
`ifdef CTRL_ILLEGAL_TRAP_EN
        next_lit = 11;
        trap_seq(3);
`else
        next_lit = 12;
        instr(4'd15, 0, 0, n);
        next_lit = 13;
        idle(1, 0);
        rst_cycle('0);
`endif
        next_lit = 0;
        idle(1, 1);
        instr(4'd0, 0, 0, n);
        ld_abort(2);
        next_lit = 0; next_lit2 = 0;
        idle(2, 1);
        for (int i = 0; i < 5; i++) instr(4'd10, 0, 0, n);
        next_lit = 5; next_lit2 = 3;
        instr(4'd7, 0, 0, n);  chk("lat_ld", n, 5);
        instr(4'd15, 0, 0, n);
        next_lit = 7; next_lit2 = 3;
        idle(2, 0);

        play();
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 Parameter OPW, default 4, opcode width; OPW SHALL be at least 4.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 Run  input  1  start request, sampled in IDLE.
REQ-006 Opcode  input  OPW  instruction opcode from the external instruction register, valid in DECODE.
REQ-007 MemReady  input  1  memory completion handshake for fetch, load and store.
REQ-008 Outputs, 1 bit each, active-high: PCWr, IRWr, RegWr, RegDes, AluSrc, Mem2Reg, MemR, MemW, Branch, Jump, sti, Busy, IllegalOp.
REQ-009 InstrCount  output  CNT_W  count of retired instructions.

Function
REQ-010 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP; state SHALL be registered, and outputs SHALL be decoded from the state and latched opcode op_q.
REQ-011 Opcode map: 0-5 R-type ALU; 6 st; 7 ld; 8 ALU-immediate; 9 branch; 10 jump; all-ones HALT; every other code illegal.
REQ-012 IDLE: all outputs 0; IDLE->FETCH when Run=1, else stay in IDLE.
REQ-013 FETCH: MemR=1 and Busy=1; stay while MemReady=0; when MemReady=1, assert PCWr=1 and IRWr=1 in that cycle, then go to DECODE.
REQ-014 DECODE: latch op_q<=Opcode; jump asserts Jump=1 and PCWr=1, retires and goes to FETCH; HALT retires and goes to IDLE; illegal opcode per REQ-027/028; all other opcodes go to EXEC.
REQ-015 EXEC, R-type: AluSrc=0, then WB.
REQ-016 EXEC, immediate, ld and st: AluSrc=1; ld and st go to MEM; immediate goes to WB.
REQ-017 EXEC, branch: Branch=1 and AluSrc=0, retire, then FETCH.
REQ-018 MEM, ld: MemR=1 until MemReady=1, then WB.
REQ-019 MEM, st: MemW=1 and sti=1 until MemReady=1, then retire and go to FETCH.
REQ-020 WB: RegWr=1 for one cycle; RegDes=1 for R-type, else 0; Mem2Reg=1 for ld only; retire, then FETCH.
REQ-021 Latency with MemReady tied high: jump 2 cycles, branch 3, R-type/immediate/st 4, ld 5; each MemReady=0 cycle adds one cycle.
REQ-022 Retire SHALL increment InstrCount by 1, saturating at all-ones with no wrap.
REQ-023 MemR and MemW SHALL never be 1 in the same cycle.
REQ-024 Busy SHALL be 1 in every state except IDLE and TRAP.
REQ-025 Run SHALL be ignored outside IDLE; MemReady SHALL be ignored outside FETCH and MEM.

Reset
REQ-026 While rst_n=0 at a clock edge: state<=IDLE, op_q<=0, InstrCount<=0, IllegalOp<=0, so every output is 0 the next cycle, including when reset lands mid-instruction or mid-handshake; nothing retires on an aborted instruction.

Configuration
REQ-027 With CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE SHALL go to TRAP, with IllegalOp=1, all other outputs 0, and no retire; only rst_n=0 leaves TRAP.
REQ-028 Without CTRL_ILLEGAL_TRAP_EN: an illegal opcode SHALL act as a NOP (retire, DECODE->FETCH), IllegalOp SHALL be tied 0, and TRAP SHALL be absent.

Verification
REQ-029 Reset, Run=1, MemReady=1, Opcode=0 -> states FETCH,DECODE,EXEC,WB repeat every 4 cycles; RegWr=1 and RegDes=1 in WB; InstrCount=1 after the first WB.
REQ-030 Opcode=7, MemReady low for 3 MEM cycles -> MemR=1 held for 4 MEM cycles; then WB with Mem2Reg=1 and RegWr=1; total 8 cycles.
REQ-031 Opcode=6 -> MemW=1 and sti=1 in MEM only; RegWr never 1; 4 cycles.
REQ-032 Opcode=10 then Opcode=9 -> Jump=1 and PCWr=1 in DECODE (2 cycles); then Branch=1 in EXEC (3 cycles); InstrCount +2.
REQ-033 Opcode=12, macro defined -> TRAP with IllegalOp=1 and Busy=0, held; macro undefined -> FETCH after DECODE, InstrCount +1.
REQ-034 rst_n=0 in MEM of ld with MemReady=0 -> next cycle IDLE, all outputs 0, InstrCount=0; CNT_W=2 with 5 retires -> InstrCount=3.
